bus_arbiter: RTL and testbench

- Round-robin arbiter for the shared internal register/ALU bus (the mux_val / mux_addr select path).
- Lets up to NREQ masters take the bus in turn: the instruction sequencer, a debug loader and a DMA-style register initialiser.
- Drives the bus select/direction from the granted master and adds a mandatory 1-cycle turnaround between owners.
- Force-releases any master that holds the bus past MAX_HOLD cycles.

---
 rtl/bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_bus_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared register/ALU select bus.
// Registered grant, 1-cycle turnaround between owners, forced release after MAX_HOLD.
module bus_arbiter_mask (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic set,
  output logic mask
);
  // A timed-out master stays locked out until it drops its request once.
  always_ff @(posedge clk or negedge rst)
    if (!rst) mask <= 1'b0;
    else      mask <= set | (mask & req);
endmodule

module bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int ADDR_W   = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ-1:0]          req_wr,
  output logic [NREQ-1:0]          gnt,
  output logic                     bus_val,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic                     bus_busy,
  output logic                     timeout_err
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     rr_ptr, rr_n, owner, owner_n, owner_inc, sel;
  logic [7:0]        hold_cnt, hold_n;
  logic [NREQ-1:0]   mask, mask_set, elig, gnt_n;
  logic              sel_vld, val_n, terr_n;
  logic [ADDR_W-1:0] addr_n;

  for (genvar g = 0; g < NREQ; g++) begin : g_mask
    bus_arbiter_mask u_mask (
      .clk  (clk),
      .rst  (rst),
      .req  (req[g]),
      .set  (mask_set[g]),
      .mask (mask[g])
    );
  end

  assign elig      = req & ~mask;
  assign bus_busy  = (state != IDLE);
  assign owner_inc = (owner == PW'(NREQ-1)) ? '0 : owner + 1'b1;

  // First eligible index at or after rr_ptr, wrapping.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!sel_vld && elig[(int'(rr_ptr) + i) % NREQ]) begin
        sel_vld = 1'b1;
        sel     = PW'((int'(rr_ptr) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    owner_n  = owner;
    hold_n   = hold_cnt;
    rr_n     = rr_ptr;
    mask_set = '0;
    val_n    = bus_val;
    addr_n   = bus_addr;
    terr_n   = 1'b0;
    case (state)
      IDLE: begin
        gnt_n = '0;
        val_n = 1'b0;
        if (sel_vld) begin
          state_n = GRANT;
          gnt_n   = NREQ'(1) << sel;
          owner_n = sel;
          hold_n  = 8'd1;
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          state_n = TURN;
          gnt_n   = '0;
          val_n   = 1'b0;
          rr_n    = owner_inc;
        end else if (hold_cnt == 8'(MAX_HOLD)) begin
          state_n         = TURN;
          gnt_n           = '0;
          val_n           = 1'b0;
          rr_n            = owner_inc;
          mask_set[owner] = 1'b1;
          terr_n          = 1'b1;
        end else begin
          hold_n = hold_cnt + 8'd1;
          addr_n = req_addr[int'(owner)*ADDR_W +: ADDR_W];
          val_n  = req_wr[owner];
        end
      end
      TURN: begin
        state_n = IDLE;
        gnt_n   = '0;
        val_n   = 1'b0;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        val_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= IDLE;
      gnt         <= '0;
      owner       <= '0;
      hold_cnt    <= '0;
      rr_ptr      <= '0;
      bus_val     <= 1'b0;
      bus_addr    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      gnt         <= gnt_n;
      owner       <= owner_n;
      hold_cnt    <= hold_n;
      rr_ptr      <= rr_n;
      bus_val     <= val_n;
      bus_addr    <= addr_n;
      timeout_err <= terr_n;
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed vector bench for bus_arbiter: cycle table plus an async-reset sequence.
module tb_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_addr;
  logic [3:0]  req_wr;
  logic [3:0]  gnt;
  logic        bus_val;
  logic [3:0]  bus_addr;
  logic        bus_busy;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  bus_arbiter #(.NREQ(4), .ADDR_W(4), .MAX_HOLD(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_addr    (req_addr),
    .req_wr      (req_wr),
    .gnt         (gnt),
    .bus_val     (bus_val),
    .bus_addr    (bus_addr),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] q;
    logic [3:0] g;
    logic       b;
    logic       v;
    logic [3:0] a;
    logic       t;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic [3:0] q, logic [3:0] g, logic b,
                              logic v, logic [3:0] a, logic t);
    vec_t x;
    x.r = r; x.q = q; x.g = g; x.b = b; x.v = v; x.a = a; x.t = t;
    vecs.push_back(x);
  endfunction

  // Packed as {gnt, bus_busy, bus_val, bus_addr, timeout_err}.
  task automatic check(string name, logic [10:0] exp);
    logic [10:0] got;
    got = {gnt, bus_busy, bus_val, bus_addr, timeout_err};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got gnt=%b busy=%b val=%b addr=%h terr=%b, want gnt=%b busy=%b val=%b addr=%h terr=%b",
               name, got[10:7], got[6], got[5], got[4:1], got[0],
               exp[10:7], exp[6], exp[5], exp[4:1], exp[0]);
    end
  endtask

  initial begin
    // Master addr slices: m0=1, m1=5, m2=A, m3=3; writers: m0, m2.
    req_addr = 16'h3A51;
    req_wr   = 4'b0101;
    rst      = 1'b0;
    req      = 4'b0000;

    // reset with all requesting, release -> master 0 on first edge
    repeat (3) add(0, 4'hF, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'hF, 4'h1, 1, 0, 4'h0, 0);
    add(1, 4'h0, 4'h0, 1, 0, 4'h0, 0);
    add(1, 4'h0, 4'h0, 0, 0, 4'h0, 0);
    // single master 2 for 4 cycles
    add(1, 4'h4, 4'h4, 1, 0, 4'h0, 0);
    repeat (3) add(1, 4'h4, 4'h4, 1, 1, 4'hA, 0);
    add(1, 4'h0, 4'h0, 1, 0, 4'hA, 0);
    add(1, 4'h0, 4'h0, 0, 0, 4'hA, 0);
    add(0, 4'h0, 4'h0, 0, 0, 4'h0, 0);
    // round robin 0,1,2,3,0 with one-cycle drops
    add(1, 4'hF, 4'h1, 1, 0, 4'h0, 0);
    add(1, 4'hF, 4'h1, 1, 1, 4'h1, 0);
    add(1, 4'hE, 4'h0, 1, 0, 4'h1, 0);
    add(1, 4'hF, 4'h0, 0, 0, 4'h1, 0);
    add(1, 4'hF, 4'h2, 1, 0, 4'h1, 0);
    add(1, 4'hF, 4'h2, 1, 0, 4'h5, 0);
    add(1, 4'hD, 4'h0, 1, 0, 4'h5, 0);
    add(1, 4'hF, 4'h0, 0, 0, 4'h5, 0);
    add(1, 4'hF, 4'h4, 1, 0, 4'h5, 0);
    add(1, 4'hF, 4'h4, 1, 1, 4'hA, 0);
    add(1, 4'hB, 4'h0, 1, 0, 4'hA, 0);
    add(1, 4'hF, 4'h0, 0, 0, 4'hA, 0);
    add(1, 4'hF, 4'h8, 1, 0, 4'hA, 0);
    add(1, 4'hF, 4'h8, 1, 0, 4'h3, 0);
    add(1, 4'h7, 4'h0, 1, 0, 4'h3, 0);
    add(1, 4'hF, 4'h0, 0, 0, 4'h3, 0);
    add(1, 4'hF, 4'h1, 1, 0, 4'h3, 0);
    add(1, 4'hF, 4'h1, 1, 1, 4'h1, 0);
    add(1, 4'h0, 4'h0, 1, 0, 4'h1, 0);
    add(1, 4'h0, 4'h0, 0, 0, 4'h1, 0);
    // timeout: master 1 holds 8 cycles with master 3 pending
    add(1, 4'hA, 4'h2, 1, 0, 4'h1, 0);
    repeat (7) add(1, 4'hA, 4'h2, 1, 0, 4'h5, 0);
    add(1, 4'hA, 4'h0, 1, 0, 4'h5, 1);
    add(1, 4'hA, 4'h0, 0, 0, 4'h5, 0);
    add(1, 4'hA, 4'h8, 1, 0, 4'h5, 0);
    add(1, 4'hA, 4'h8, 1, 0, 4'h3, 0);
    add(1, 4'h2, 4'h0, 1, 0, 4'h3, 0);
    add(1, 4'h2, 4'h0, 0, 0, 4'h3, 0);
    add(1, 4'h2, 4'h0, 0, 0, 4'h3, 0);
    add(1, 4'h0, 4'h0, 0, 0, 4'h3, 0);
    add(1, 4'h2, 4'h2, 1, 0, 4'h3, 0);
    add(1, 4'h0, 4'h0, 1, 0, 4'h3, 0);
    add(1, 4'h0, 4'h0, 0, 0, 4'h3, 0);
    // wrap: master 3 releases, then 0 and 3 both request -> 0
    add(1, 4'h8, 4'h8, 1, 0, 4'h3, 0);
    add(1, 4'h1, 4'h0, 1, 0, 4'h3, 0);
    add(1, 4'h9, 4'h0, 0, 0, 4'h3, 0);
    add(1, 4'h9, 4'h1, 1, 0, 4'h3, 0);
    add(1, 4'h9, 4'h1, 1, 1, 4'h1, 0);
    add(1, 4'h0, 4'h0, 1, 0, 4'h1, 0);
    add(1, 4'h0, 4'h0, 0, 0, 4'h1, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].r;
      req = vecs[i].q;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            {vecs[i].g, vecs[i].b, vecs[i].v, vecs[i].a, vecs[i].t});
    end

    // async reset mid-grant drops everything before the next edge
    req = 4'b0010;
    @(posedge clk);
    #1;
    check("grant_m1", {4'h2, 1'b1, 1'b0, 4'h1, 1'b0});
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", {4'h0, 1'b0, 1'b0, 4'h0, 1'b0});
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 4'b0011;
    @(posedge clk);
    #1;
    check("post_rst_rr0", {4'h1, 1'b1, 1'b0, 4'h0, 1'b0});
    @(posedge clk);
    #1;
    check("post_rst_bus", {4'h1, 1'b1, 1'b1, 4'h1, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
